accum_sched: RTL

- Round-robin scheduler that shares one accumulator datapath among R requesters.
- Each requester opens a session, streams samples with a valid/ready handshake, and marks the final sample with Last.
- The scheduler sums the session's samples and returns the total to the requester through a result handshake tagged with the requester ID.
- Sits between sample producers (sensor/ADC front ends) and the shared accumulator, replacing per-source accumulators.

---
 rtl/accum_sched_pkg.sv | 32 +++
 rtl/accum_sched_core.sv | 33 +++
 rtl/accum_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/accum_sched_pkg.sv
// Shared types and helpers for the accum_sched round-robin accumulator scheduler.
package accum_sched_pkg;

  // Upper bound on requester count handled by the round-robin helper.
  localparam int unsigned MaxReq = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // First requesting index at or after ptr, wrapping modulo num; returns ptr if none request.
  function automatic int unsigned rr_next(input logic [MaxReq-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       num);
    int unsigned idx;
    logic        found;
    rr_next = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (i < num) begin
        idx = (ptr + i) % num;
        if (!found && req[idx[4:0]]) begin
          rr_next = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/accum_sched_core.sv
// Shared W-bit accumulator: synchronous clear beats enable; exposes the add carry-out.
module accum_core #(
  parameter int unsigned W = 8
) (
  input  logic         Clk,
  input  logic         Resetn,
  input  logic         Clr,
  input  logic         En,
  input  logic [W-1:0] Din,
  output logic [W-1:0] Q,
  output logic         Carry
);

  logic [W:0] sum;

  // Widened add so the carry-out is visible for overflow tracking.
  always_comb begin
    sum   = {1'b0, Q} + {1'b0, Din};
    Carry = sum[W];
  end

  // Accumulator register; wrap-around is modulo 2^W.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      Q <= '0;
    end else if (Clr) begin
      Q <= '0;
    end else if (En) begin
      Q <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/accum_sched.sv
// Round-robin scheduler sharing one accumulator among R requesters.
// Optional sticky overflow output enabled by defining ACCUM_SCHED_OVF_EN.
module accum_sched
  import accum_sched_pkg::*;
#(
  parameter int unsigned n = 4,
  parameter int unsigned R = 4,
  parameter int unsigned W = 8
) (
  input  logic                 Clk,
  input  logic                 Resetn,
  input  logic [R-1:0]         Req,
  input  logic [R-1:0]         Valid,
  input  logic [R-1:0]         Last,
  input  logic [R*n-1:0]       Data,
  output logic [R-1:0]         Ready,
  output logic [R-1:0]         Gnt,
  output logic                 Busy,
  output logic [W-1:0]         Result,
  output logic                 ResultValid,
  output logic [$clog2(R)-1:0] ResultId,
`ifdef ACCUM_SCHED_OVF_EN
  output logic                 ResultOvf,
`endif
  input  logic                 ResultReady
);

  localparam int unsigned IdW = $clog2(R);
  localparam logic [R-1:0] OneHot0 = R'(1);

  state_e         state_q;
  logic [R-1:0]   gnt_q;
  logic [IdW-1:0] gidx_q;
  logic [IdW-1:0] ptr_q;

  int unsigned    pick;
  logic [IdW-1:0] pick_idx;
  logic [IdW-1:0] ptr_nxt;
  logic           acc_clr;
  logic           xfer;
  logic [n-1:0]   sel_data;
  logic [W-1:0]   acc_q;
  logic           carry;

  // Arbitration, granted-sample mux and transfer decode.
  always_comb begin
    pick     = rr_next(MaxReq'(Req), 32'(ptr_q), R);
    pick_idx = IdW'(pick);
    ptr_nxt  = IdW'((pick + 1) % R);
    acc_clr  = (state_q == StIdle) && (|Req);
    xfer     = (state_q == StRun) && Valid[gidx_q];
    sel_data = '0;
    for (int i = 0; i < int'(R); i++) begin
      if (gidx_q == IdW'(i)) sel_data = Data[i*n +: n];
    end
  end

  accum_core #(
    .W (W)
  ) u_core (
    .Clk    (Clk),
    .Resetn (Resetn),
    .Clr    (acc_clr),
    .En     (xfer),
    .Din    (W'(sel_data)),
    .Q      (acc_q),
    .Carry  (carry)
  );

  // Session FSM: grant in IDLE, stream in RUN, hold result in DONE until accepted.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|Req) begin
            state_q <= StRun;
            gidx_q  <= pick_idx;
            gnt_q   <= OneHot0 << pick_idx;
            ptr_q   <= ptr_nxt;
          end
        end
        StRun: begin
          if (xfer && Last[gidx_q]) state_q <= StDone;
        end
        StDone: begin
          if (ResultReady) begin
            state_q <= StIdle;
            gnt_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ACCUM_SCHED_OVF_EN
  logic ovf_q;

  // Sticky overflow: cleared at session start, set on any carry-out during RUN.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      ovf_q <= 1'b0;
    end else if (acc_clr) begin
      ovf_q <= 1'b0;
    end else if (xfer && carry) begin
      ovf_q <= 1'b1;
    end
  end

  assign ResultOvf = ovf_q;
`else
  logic unused_carry;
  assign unused_carry = carry;
`endif

  // Outputs decoded from registered state.
  always_comb begin
    Ready       = (state_q == StRun) ? gnt_q : '0;
    Gnt         = gnt_q;
    Busy        = (state_q != StIdle);
    ResultValid = (state_q == StDone);
    Result      = acc_q;
    ResultId    = gidx_q;
  end

endmodule
